io_port_responder: RTL and testbench
====================================

// Module: io_port_responder
// PURPOSE
// - Memory-mapped I/O responder on the processor's MEM-stage data bus. It is the
//   slave side of the addr/wdata/write_en/mem_read interface.
// - Debounces the two push buttons (active-low). On each press it captures the
//   switches into INPORT0/INPORT1.
// - Holds the 32-bit OUTPORT register that drives the seven-segment decoders.
// - Returns read data with 1-cycle latency, matching the synchronous data RAM.
// PARAMETERS
// - ADDR_WIDTH      10     byte-address width of the data bus
// - SW_WIDTH        10     switch width; captured values are zero-extended to 32 bits
// - DEBOUNCE_CYCLES 50000  stable cycles required before a button level is accepted (>=2)
// - STATUS_ADDR     10'h3F4  read-only status register
// - IN0_ADDR        10'h3F8  read-only INPORT0
// - IN1_ADDR        10'h3FC  INPORT1 on read / OUTPORT on write
// PORTS
// - clk          in   1            system clock; all state on rising edge
// - rst          in   1            asynchronous, active-low reset
// - addr         in   ADDR_WIDTH   byte address from EX/MEM result
// - wdata        in   32           store data
// - write_en     in   1            store strobe, 1 cycle per access
// - mem_read     in   1            load strobe, 1 cycle per access
// - button0      in   1            raw push button, active-low, asynchronous
// - button1      in   1            raw push button, active-low, asynchronous
// - switches     in   SW_WIDTH     raw switches, asynchronous
// - io_hit       out  1            comb: addr matches any I/O address while (write_en|mem_read)
// - rdata        out  32           registered read data; 0 when rd_valid=0
// - rd_valid     out  1            1-cycle pulse, the cycle after an I/O read is accepted
// - output_port  out  32           OUTPORT register
// - in0_new      out  1            INPORT0 captured and not yet read
// - in1_new      out  1            INPORT1 captured and not yet read
// BEHAVIOUR
// - Reset (rst=0, async): all outputs and registers = 0.
//   Sync flops = 1 (released). Both FSMs enter REL.
// - Inputs: button0/1 pass through a 2-FF synchronizer. Switches are sampled
//   through a 2-FF synchronizer when captured.
// - Per-button FSM: REL -> PRESS_WAIT (sync=0) -> PRESSED (0 held DEBOUNCE_CYCLES)
//   -> REL_WAIT (sync=1) -> REL (1 held DEBOUNCE_CYCLES).
//   - Any bounce during a WAIT state returns to the prior stable state and clears the counter.
//   - Counter is 0..DEBOUNCE_CYCLES-1 and is sized with $clog2.
// - Capture happens on the PRESS_WAIT->PRESSED transition only: INPORTn <= zext(sw_sync)
//   and inN_new <= 1. There is exactly one capture per press; holding the button gives no repeats.
// - Write: write_en && addr==IN1_ADDR gives output_port <= wdata on the next edge.
//   - Writes to other I/O addresses are ignored.
//   - Writes to non-I/O addresses have no effect and io_hit=0.
// - Read: mem_read && io_hit && !write_en gives rd_valid=1 on the next cycle.
//   - rdata = STATUS {30'b0,in1_new,in0_new}, INPORT0, or INPORT1, sampled pre-edge.
//   - Reading INPORTn clears inN_new.
// - Simultaneous events:
//   - Capture and read of the same port in one cycle: rdata = old value, the new
//     value is stored, and inN_new stays 1. Capture wins the flag.
//   - write_en and mem_read together: the write executes and no read response is given.
//   - Both buttons capture in the same cycle: both ports update independently.
// - Reset mid-debounce or mid-read: the FSM aborts to REL and the pending rd_valid is dropped.
//   A button held through reset release is counted as a new press after the full debounce.
// - Latency: the switch-to-INPORT path is 2 sync cycles + DEBOUNCE_CYCLES + 1.
// CONFIGURATION
// - Macro IO_DEBOUNCE_EN.
//   - Defined: behaviour is as above.
//   - Undefined: the FSMs and counters are removed. A capture fires on the 1->0 edge
//     of the synchronized button, giving 3-cycle latency with no bounce filtering.
//     DEBOUNCE_CYCLES is ignored.
// TESTING (bench uses DEBOUNCE_CYCLES=4 with IO_DEBOUNCE_EN defined unless noted)
// - Reset:
//   - Stimulus: rst=0 with button0=0 and switches=10'h155 applied.
//   - Response: output_port=0, rdata=0, rd_valid=0, in0_new=0.
//   - Stimulus: release rst and keep button0 held.
//   - Response: INPORT0=32'h155 after 2+4+1 cycles.
// - Clean press:
//   - Stimulus: switches=10'h2AB, button1 held 0 for 10 cycles.
//   - Response: in1_new=1.
//   - Stimulus: load from 10'h3FC.
//   - Response: next cycle rd_valid=1, rdata=32'h2AB, in1_new=0.
// - Bounce:
//   - Stimulus: button0 toggles 0,1,0,1 each cycle then settles at 1.
//   - Response: no capture, in0_new=0.
//   - Stimulus: same test with IO_DEBOUNCE_EN undefined.
//   - Response: capture occurs.
// - OUTPORT write:
//   - Stimulus: store 32'h00ABCDEF to 10'h3FC.
//   - Response: output_port=32'h00ABCDEF next cycle, rd_valid stays 0.
//   - Stimulus: store to 10'h3F8.
//   - Response: output_port unchanged.
// - Collision:
//   - Stimulus: read 10'h3F8 in the capture cycle, INPORT0 old=5, new=9.
//   - Response: rdata=5, INPORT0=9, in0_new=1.
// - Non-I/O address:
//   - Stimulus: load from 10'h010.
//   - Response: io_hit=0, rd_valid=0, rdata=0.
//   - Stimulus: status read after both captures.
//   - Response: rdata=32'h3.

Source files
------------

// File: rtl/io_port_responder_if.sv
// Data-bus bundle between the MEM stage (master) and the memory-mapped I/O responder (slave).
interface io_port_responder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  write_en;
  logic                  mem_read;
  logic                  io_hit;
  logic [31:0]           rdata;
  logic                  rd_valid;

  modport master (
    output addr, wdata, write_en, mem_read,
    input  io_hit, rdata, rd_valid
  );

  modport slave (
    input  addr, wdata, write_en, mem_read,
    output io_hit, rdata, rd_valid
  );
endinterface

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: button-triggered switch capture ports, status flags and OUTPORT.
// Define IO_DEBOUNCE_EN to debounce the buttons; otherwise a synchronized falling edge captures.
module io_port_responder #(
  parameter int                    ADDR_WIDTH      = 10,
  parameter int                    SW_WIDTH        = 10,
  parameter int                    DEBOUNCE_CYCLES = 50000,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR     = 10'h3F4,
  parameter logic [ADDR_WIDTH-1:0] IN0_ADDR        = 10'h3F8,
  parameter logic [ADDR_WIDTH-1:0] IN1_ADDR        = 10'h3FC
) (
  input  logic                clk,
  input  logic                rst,
  io_port_responder_if.slave  bus,
  input  logic                button0,
  input  logic                button1,
  input  logic [SW_WIDTH-1:0] switches,
  output logic [31:0]         output_port,
  output logic                in0_new,
  output logic                in1_new
);
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

`ifdef IO_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {REL, PRESS_WAIT, PRESSED, REL_WAIT} db_state_t;
`endif

  logic [1:0]          btn_meta_reg;
  logic [1:0]          btn_sync_reg;
  logic [SW_WIDTH-1:0] sw_meta_reg;
  logic [SW_WIDTH-1:0] sw_sync_reg;
  logic [1:0]          capture;
  logic [1:0]          new_flag;
  logic [31:0]         inport [2];
  logic                hit_any;
  logic                rd_accept;
  logic [31:0]         rd_mux;
  logic [31:0]         rdata_reg;
  logic                rd_valid_reg;
  logic [31:0]         output_port_reg;

  // Buttons idle high, so their synchronizers reset to the released level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_meta_reg <= 2'b11;
      btn_sync_reg <= 2'b11;
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
    end else begin
      btn_meta_reg <= {button1, button0};
      btn_sync_reg <= btn_meta_reg;
      sw_meta_reg  <= switches;
      sw_sync_reg  <= sw_meta_reg;
    end
  end

  assign hit_any    = (bus.addr == STATUS_ADDR) || (bus.addr == IN0_ADDR) || (bus.addr == IN1_ADDR);
  assign bus.io_hit = hit_any && (bus.write_en || bus.mem_read);
  // A store takes priority over a simultaneous load: no read response then.
  assign rd_accept  = bus.mem_read && bus.io_hit && !bus.write_en;

  always_comb begin
    rd_mux = '0;
    if (bus.addr == STATUS_ADDR)   rd_mux = {30'b0, new_flag[1], new_flag[0]};
    else if (bus.addr == IN0_ADDR) rd_mux = inport[0];
    else if (bus.addr == IN1_ADDR) rd_mux = inport[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg       <= '0;
      rd_valid_reg    <= 1'b0;
      output_port_reg <= '0;
    end else begin
      rd_valid_reg <= rd_accept;
      rdata_reg    <= rd_accept ? rd_mux : 32'd0;
      if (bus.write_en && (bus.addr == IN1_ADDR)) output_port_reg <= bus.wdata;
    end
  end

  assign bus.rdata    = rdata_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign output_port  = output_port_reg;
  assign in0_new      = new_flag[0];
  assign in1_new      = new_flag[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    localparam logic [ADDR_WIDTH-1:0] PORT_ADDR = (gi == 0) ? IN0_ADDR : IN1_ADDR;

    logic [31:0] inport_reg;
    logic        new_reg;
    logic        rd_this;

`ifdef IO_DEBOUNCE_EN
    db_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             cap;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_reg <= REL;
        cnt_reg   <= '0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
      end
    end

    // A bounce inside either WAIT state falls back to the previous stable level.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cap        = 1'b0;
      case (state_reg)
        REL: begin
          if (!btn_sync_reg[gi]) begin
            state_next = PRESS_WAIT;
            cnt_next   = '0;
          end
        end
        PRESS_WAIT: begin
          if (btn_sync_reg[gi]) begin
            state_next = REL;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = PRESSED;
            cnt_next   = '0;
            cap        = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (btn_sync_reg[gi]) begin
            state_next = REL_WAIT;
            cnt_next   = '0;
          end
        end
        REL_WAIT: begin
          if (!btn_sync_reg[gi]) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = REL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = REL;
          cnt_next   = '0;
        end
      endcase
    end

    assign capture[gi] = cap;
`else
    logic prev_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_reg <= 1'b1;
      else      prev_reg <= btn_sync_reg[gi];
    end

    assign capture[gi] = prev_reg && !btn_sync_reg[gi];
`endif

    assign rd_this = rd_accept && (bus.addr == PORT_ADDR);

    // Capture beats a same-cycle read for the flag; the read still returns the old value.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        inport_reg <= '0;
        new_reg    <= 1'b0;
      end else if (capture[gi]) begin
        inport_reg <= 32'(sw_sync_reg);
        new_reg    <= 1'b1;
      end else if (rd_this) begin
        new_reg    <= 1'b0;
      end
    end

    assign inport[gi]   = inport_reg;
    assign new_flag[gi] = new_reg;
  end
endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: directed scenarios, then random bus and button traffic
// scored against a behavioural model of the ports, flags and debounce filter.
module tb_io_port_responder;
  localparam int DC = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int CAP_LAT = 2 + DC + 1;
`else
  localparam int CAP_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        button0;
  logic        button1;
  logic [9:0]  switches;
  logic [31:0] output_port;
  logic        in0_new;
  logic        in1_new;

  io_port_responder_if #(.ADDR_WIDTH(10)) bus ();

  io_port_responder #(
    .ADDR_WIDTH(10),
    .SW_WIDTH(10),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .button0(button0),
    .button1(button1),
    .switches(switches),
    .output_port(output_port),
    .in0_new(in0_new),
    .in1_new(in1_new)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit last_hit;

  // Reference model state: what a user of the ports would observe.
  bit          m_s0 [2];
  bit          m_s1 [2];
  bit          m_level [2];
  int          m_run [2];
  bit          m_prev [2];
  logic [9:0]  m_sw0, m_sw1;
  logic [31:0] m_port [2];
  bit          m_new [2];
  logic [31:0] m_out, m_rdata;
  bit          m_rvalid;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s0[i] = 1'b1; m_s1[i] = 1'b1; m_level[i] = 1'b1;
      m_run[i] = 0; m_prev[i] = 1'b1; m_port[i] = '0; m_new[i] = 1'b0;
    end
    m_sw0 = '0; m_sw1 = '0; m_out = '0; m_rdata = '0; m_rvalid = 1'b0;
  endfunction

  // One clock edge of the model, from the inputs present before that edge.
  task automatic model_step(input bit b0, input bit b1, input logic [9:0] sw, input logic [9:0] a,
                            input logic [31:0] wd, input bit we, input bit rd, output bit hit);
    bit          cap [2];
    bit          acc;
    logic [31:0] rv;
    hit = ((a == 10'h3F4) || (a == 10'h3F8) || (a == 10'h3FC)) && (we || rd);
    acc = rd && hit && !we;
    rv  = '0;
    if (acc) begin
      if (a == 10'h3F4)      rv = {30'b0, m_new[1], m_new[0]};
      else if (a == 10'h3F8) rv = m_port[0];
      else                   rv = m_port[1];
    end
    for (int i = 0; i < 2; i++) begin
`ifdef IO_DEBOUNCE_EN
      // Level is accepted once DC+1 consecutive samples disagree with the current stable level.
      cap[i] = 1'b0;
      if (m_s1[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DC + 1) begin
          m_level[i] = !m_level[i];
          m_run[i]   = 0;
          cap[i]     = !m_level[i];
        end
      end else begin
        m_run[i] = 0;
      end
`else
      cap[i]    = m_prev[i] && !m_s1[i];
      m_prev[i] = m_s1[i];
`endif
    end
    if (acc && a == 10'h3F8) m_new[0] = 1'b0;
    if (acc && a == 10'h3FC) m_new[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (cap[i]) begin
        m_port[i] = {22'b0, m_sw1};
        m_new[i]  = 1'b1;
      end
    end
    if (we && a == 10'h3FC) m_out = wd;
    m_rdata  = rv;
    m_rvalid = acc;
    m_s1[0] = m_s0[0]; m_s1[1] = m_s0[1];
    m_s0[0] = b0;      m_s0[1] = b1;
    m_sw1   = m_sw0;   m_sw0   = sw;
  endtask

  // Called at a falling edge; applies one cycle of inputs and scores every output.
  task automatic cycle(input bit b0, input bit b1, input logic [9:0] sw, input logic [9:0] a,
                       input logic [31:0] wd, input bit we, input bit rd);
    bit hit_exp;
    button0 = b0; button1 = b1; switches = sw;
    bus.addr = a; bus.wdata = wd; bus.write_en = we; bus.mem_read = rd;
    #1;
    last_hit = bus.io_hit;
    model_step(b0, b1, sw, a, wd, we, rd, hit_exp);
    check("io_hit", 32'(bus.io_hit), 32'(hit_exp));
    @(posedge clk);
    @(negedge clk);
    check("rd_valid", 32'(bus.rd_valid), 32'(m_rvalid));
    check("rdata", bus.rdata, m_rdata);
    check("output_port", output_port, m_out);
    check("in0_new", 32'(in0_new), 32'(m_new[0]));
    check("in1_new", 32'(in1_new), 32'(m_new[1]));
    if (we || rd)
      $display("txn t=%0t addr=%h we=%0d rd=%0d wdata=%h -> rd_valid=%0d rdata=%h out=%h",
               $time, a, we, rd, wd, bus.rd_valid, bus.rdata, output_port);
  endtask

  task automatic idle(input bit b0, input bit b1, input logic [9:0] sw, input int n);
    for (int k = 0; k < n; k++) cycle(b0, b1, sw, 10'h000, 32'd0, 1'b0, 1'b0);
  endtask

  // Asserts reset asynchronously while a status load is on the bus, then releases it.
  task automatic do_reset(input bit b0, input bit b1);
    button0 = b0; button1 = b1;
    bus.addr = 10'h3F4; bus.wdata = '0; bus.write_en = 1'b0; bus.mem_read = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_output_port", output_port, 32'd0);
    check("rst_flags", {30'b0, in1_new, in0_new}, 32'd0);
    bus.mem_read = 1'b0;
    rst = 1'b1;
    $display("txn t=%0t reset pulse", $time);
  endtask

  bit         rb [2];
  int         rhold [2];
  logic [9:0] rsw;
  logic [9:0] raddr;

  initial begin
    // Reset with button0 held and switches preset.
    rst = 1'b0; button0 = 1'b0; button1 = 1'b1; switches = 10'h155;
    bus.addr = '0; bus.wdata = '0; bus.write_en = 1'b0; bus.mem_read = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_output_port", output_port, 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_in0_new", 32'(in0_new), 32'd0);
    rst = 1'b1;
    idle(1'b0, 1'b1, 10'h155, CAP_LAT - 1);
    check("held_press_not_yet", 32'(in0_new), 32'd0);
    idle(1'b0, 1'b1, 10'h155, 1);
    check("held_press_captured", 32'(in0_new), 32'd1);
    cycle(1'b0, 1'b1, 10'h155, 10'h3F8, 32'd0, 1'b0, 1'b1);
    check("held_press_inport0", bus.rdata, 32'h155);
    check("held_press_flag_cleared", 32'(in0_new), 32'd0);

    // Clean press on button1.
    idle(1'b0, 1'b0, 10'h2AB, 10);
    check("clean_in1_new", 32'(in1_new), 32'd1);
    cycle(1'b1, 1'b1, 10'h2AB, 10'h3FC, 32'd0, 1'b0, 1'b1);
    check("clean_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("clean_rdata", bus.rdata, 32'h2AB);
    check("clean_in1_cleared", 32'(in1_new), 32'd0);
    idle(1'b1, 1'b1, 10'h2AB, 15);

    // Bounce on button0.
    idle(1'b0, 1'b1, 10'h0F0, 1);
    idle(1'b1, 1'b1, 10'h0F0, 1);
    idle(1'b0, 1'b1, 10'h0F0, 1);
    idle(1'b1, 1'b1, 10'h0F0, 12);
`ifdef IO_DEBOUNCE_EN
    check("bounce_filtered", 32'(in0_new), 32'd0);
`else
    check("bounce_captured", 32'(in0_new), 32'd1);
`endif

    // OUTPORT writes.
    cycle(1'b1, 1'b1, 10'h0F0, 10'h3FC, 32'h00ABCDEF, 1'b1, 1'b0);
    check("out_write", output_port, 32'h00ABCDEF);
    check("out_write_no_rd", 32'(bus.rd_valid), 32'd0);
    cycle(1'b1, 1'b1, 10'h0F0, 10'h3F8, 32'h12345678, 1'b1, 1'b0);
    check("out_write_other_ignored", output_port, 32'h00ABCDEF);
    cycle(1'b1, 1'b1, 10'h0F0, 10'h3FC, 32'h11223344, 1'b1, 1'b1);
    check("wr_rd_together_out", output_port, 32'h11223344);
    check("wr_rd_together_no_rd", 32'(bus.rd_valid), 32'd0);

    // Collision: INPORT0 goes 5 -> 9 in the cycle it is read; both buttons capture together.
    idle(1'b0, 1'b1, 10'h005, CAP_LAT + 2);
    idle(1'b1, 1'b1, 10'h009, 15);
    for (int k = 0; k < CAP_LAT; k++)
      cycle(1'b0, 1'b0, 10'h009, (k == CAP_LAT - 1) ? 10'h3F8 : 10'h000, 32'd0, 1'b0, k == CAP_LAT - 1);
    check("collision_rdata_old", bus.rdata, 32'h5);
    check("collision_in0_new", 32'(in0_new), 32'd1);
    check("collision_in1_new", 32'(in1_new), 32'd1);
    cycle(1'b0, 1'b0, 10'h009, 10'h3F4, 32'd0, 1'b0, 1'b1);
    check("status_both", bus.rdata, 32'h3);
    cycle(1'b0, 1'b0, 10'h009, 10'h3F8, 32'd0, 1'b0, 1'b1);
    check("collision_inport0_new", bus.rdata, 32'h9);
    cycle(1'b0, 1'b0, 10'h009, 10'h3FC, 32'd0, 1'b0, 1'b1);
    check("both_inport1", bus.rdata, 32'h9);

    // Non-I/O load.
    cycle(1'b1, 1'b1, 10'h009, 10'h010, 32'd0, 1'b0, 1'b1);
    check("nonio_hit", 32'(last_hit), 32'd0);
    check("nonio_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("nonio_rdata", bus.rdata, 32'd0);

    // Reset while a read is pending.
    do_reset(1'b1, 1'b1);

    // Random traffic.
    rb[0] = 1'b1; rb[1] = 1'b1; rhold[0] = 3; rhold[1] = 5; rsw = 10'h3C3;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(rb[0], rb[1]);
      end else begin
        for (int i = 0; i < 2; i++) begin
          rhold[i]--;
          if (rhold[i] <= 0) begin
            rb[i]    = !rb[i];
            rhold[i] = $urandom_range(1, 14);
          end
        end
        if ($urandom_range(0, 7) == 0) rsw = 10'($urandom);
        case ($urandom_range(0, 4))
          0:       raddr = 10'h3F4;
          1:       raddr = 10'h3F8;
          2:       raddr = 10'h3FC;
          default: raddr = 10'($urandom);
        endcase
        cycle(rb[0], rb[1], rsw, raddr, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 4) < 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
